dram_port_arbiter: RTL

Two-requester arbiter and sequencer for a single-port, synchronous-read data RAM with a 1-cycle registered read address. It is the RAM's only master. Typical requesters are cache refill (port 0) and write-back (port 1). Each cycle it grants at most one requester and drives the RAM address, write-data and write-enable lines. One cycle later it returns read data to the granted requester with a valid pulse. A lock input lets a requester keep ownership for multi-beat line transfers.

---
 rtl/dram_arb_pkg.sv | 30 +++
 rtl/dram_arb_pick.sv | 18 +
 rtl/dram_port_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/dram_arb_pkg.sv
// rtl/dram_arb_pkg.sv - shared states, port indices and next-state helper for dram_port_arbiter
package dram_arb_pkg;

    // Ownership states, kept as plain constants so older tools can read them.
    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE = 2'd0;
    localparam arb_state_t OWN0 = 2'd1;
    localparam arb_state_t OWN1 = 2'd2;

    // Port indices; they also serve as the one-bit port id stored with a pending read.
    localparam logic [0:0] PORT0 = 1'b0;
    localparam logic [0:0] PORT1 = 1'b1;

    // State after an unlocked arbitration: the winner takes ownership only if
    // it asserts its lock in the same cycle.
    function automatic arb_state_t idle_next(input logic [1:0] win,
                                             input logic       lock0,
                                             input logic       lock1);
        arb_state_t nxt;
        nxt = IDLE;
        if (win[PORT0] && lock0) begin
            nxt = OWN0;
        end else if (win[PORT1] && lock1) begin
            nxt = OWN1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/dram_arb_pick.sv
// rtl/dram_arb_pick.sv - combinational two-way picker with a one-hot winner
module dram_arb_pick
    import dram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] win
);

    // A single requester always wins. On a tie the port other than `last`
    // wins; holding last at 1 gives port 0 fixed priority.
    always_comb begin
        win        = 2'b00;
        win[PORT0] = req[PORT0] & (~req[PORT1] | last);
        win[PORT1] = req[PORT1] & (~req[PORT0] | ~last);
    end

endmodule

// File: rtl/dram_port_arbiter.sv
// rtl/dram_port_arbiter.sv - two-port arbiter/sequencer for a sync-read RAM; DRAM_ARB_RR_EN selects round-robin
module dram_port_arbiter
    import dram_arb_pkg::*;
#(
    parameter int AWIDTH = 3,
    parameter int DWIDTH = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic              we0,
    input  logic              we1,
    input  logic [AWIDTH-1:0] addr0,
    input  logic [AWIDTH-1:0] addr1,
    input  logic [DWIDTH-1:0] din0,
    input  logic [DWIDTH-1:0] din1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DWIDTH-1:0] rdata0,
    output logic [DWIDTH-1:0] rdata1,
    output logic              ram_we,
    output logic [AWIDTH-1:0] ram_addr,
    output logic [DWIDTH-1:0] ram_din,
    input  logic [DWIDTH-1:0] ram_dout
);

    arb_state_t state_q;
    arb_state_t state_d;
    logic [1:0] req_v;
    logic [1:0] idle_win;
    logic [1:0] win;
    logic       pick_last;
    logic       any_gnt;
    logic       sel_port;
    logic       sel_we;
    logic       pend_q;
    logic [0:0] pid_q;

    assign req_v = {req1, req0};

`ifdef DRAM_ARB_RR_EN
    logic last_q;

    assign pick_last = last_q;

    // Round-robin pointer: remembers the most recent winner; starts at 1 so port 0 wins first.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= 1'b1;
        end else if (any_gnt) begin
            last_q <= sel_port;
        end
    end
`else
    // Fixed priority: a constant pointer of 1 makes port 0 win every tie.
    assign pick_last = 1'b1;
`endif

    dram_arb_pick u_pick (
        .req  (req_v),
        .last (pick_last),
        .win  (idle_win)
    );

    // Grant and next-state: an owner with a request is served outright; a locked
    // owner without a request holds the RAM idle; otherwise arbitrate normally.
    always_comb begin
        win     = 2'b00;
        state_d = state_q;
        case (state_q)
            IDLE: begin
                win     = idle_win;
                state_d = idle_next(idle_win, lock0, lock1);
            end
            OWN0: begin
                if (req0) begin
                    win     = 2'b01;
                    state_d = lock0 ? OWN0 : IDLE;
                end else if (lock0) begin
                    win     = 2'b00;
                    state_d = OWN0;
                end else begin
                    win     = idle_win;
                    state_d = idle_next(idle_win, lock0, lock1);
                end
            end
            OWN1: begin
                if (req1) begin
                    win     = 2'b10;
                    state_d = lock1 ? OWN1 : IDLE;
                end else if (lock1) begin
                    win     = 2'b00;
                    state_d = OWN1;
                end else begin
                    win     = idle_win;
                    state_d = idle_next(idle_win, lock0, lock1);
                end
            end
            default: begin
                win     = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    assign gnt0     = win[PORT0];
    assign gnt1     = win[PORT1];
    assign any_gnt  = |win;
    assign sel_port = win[PORT1];
    assign sel_we   = sel_port ? we1 : we0;

    // RAM lines carry the winner's access and are parked at zero when nobody is granted.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (any_gnt) begin
            ram_we   = sel_we;
            ram_addr = sel_port ? addr1 : addr0;
            ram_din  = sel_port ? din1 : din0;
        end
    end

    // Ownership state plus the one-deep read tracker that steers next cycle's RAM data.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pend_q  <= 1'b0;
            pid_q   <= PORT0;
        end else begin
            state_q <= state_d;
            pend_q  <= any_gnt & ~sel_we;
            pid_q   <= sel_port;
        end
    end

    assign rvalid0 = pend_q & (pid_q == PORT0);
    assign rvalid1 = pend_q & (pid_q == PORT1);
    assign rdata0  = rvalid0 ? ram_dout : '0;
    assign rdata1  = rvalid1 ? ram_dout : '0;

endmodule
